decoder_2x4_strobe: RTL and testbench

DECODER_2X4_STROBE -- requirements
Module: decoder_2x4_strobe

---
 rtl/decoder_pkg.sv | 15 +
 rtl/decoder_2x4.sv | 15 +
 rtl/decoder_2x4_strobe.sv | 91 +++++++++
 tb/tb_decoder_2x4_strobe.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and widths for the 2-to-4 strobe decoder.
// The state enum is used by the strobe FSM; the widths size its datapath.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int CODE_W = 2;
    localparam int OUT_W  = 4;
    localparam int CNT_W  = 8;

endpackage

// File: rtl/decoder_2x4.sv
// Combinational binary-to-one-hot decoder: out[k] is high only when in == k.
import decoder_pkg::*;

module decoder_2x4 (
    input  logic [CODE_W-1:0] in,
    output logic [OUT_W-1:0]  out
);

    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
            assign out[gi] = (in == CODE_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/decoder_2x4_strobe.sv
// Accepts a 2-bit code, holds its one-hot decode for HOLD_CYCLES cycles, then
// enforces GAP_CYCLES idle cycles before the next code; abort cancels a strobe.
import decoder_pkg::*;

module decoder_2x4_strobe #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in,
    input  logic              abort,
    output logic              in_ready,
    output logic [OUT_W-1:0]  out,
    output logic              busy,
    output logic              done
);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [CODE_W-1:0]  code_reg, code_next;
    logic [OUT_W-1:0]   onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            code_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            code_reg  <= code_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        code_next  = code_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid && in_ready) begin
                    code_next  = in;
                    state_next = HOLD;
                    cnt_next   = CNT_W'(HOLD_CYCLES - 1);
                end
            end
            HOLD: begin
                // abort wins over the terminal count so no done is issued
                if (abort) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == '0) begin
                    if (GAP_CYCLES > 0) begin
                        state_next = GAP;
                        cnt_next   = CNT_W'(GAP_CYCLES - 1);
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            GAP: begin
                if (abort || cnt_reg == '0) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    decoder_2x4 u_decoder_2x4 (
        .in  (code_reg),
        .out (onehot)
    );

    // Outputs decode only registered state; abort gates the handshake and done.
    assign in_ready = (state_reg == IDLE) && !abort;
    assign out      = (state_reg == HOLD) ? onehot : '0;
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == HOLD) && (cnt_reg == '0) && !abort;

endmodule

// File: tb/tb_decoder_2x4_strobe.sv
// Bench for decoder_2x4_strobe: two instances (4/1 and 1/0 hold/gap) share
// stimulus and are compared each cycle to a remaining-cycles reference model.
module tb_decoder_2x4_strobe;

    logic       clk = 1'b0;
    logic       rst, in_valid, abort;
    logic [1:0] in_code;
    logic       in_ready0, busy0, done0, in_ready1, busy1, done1;
    logic [3:0] out0, out1;

    always #5 clk = ~clk;

    decoder_2x4_strobe #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_code), .abort(abort),
        .in_ready(in_ready0), .out(out0), .busy(busy0), .done(done0)
    );

    decoder_2x4_strobe #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_code), .abort(abort),
        .in_ready(in_ready1), .out(out1), .busy(busy1), .done(done1)
    );

    int passed = 0;
    int total  = 0;

    // Reference model: cycles of strobe and of gap still to come per instance.
    int hc[2] = '{4, 1};
    int gc[2] = '{1, 0};
    int hl[2], gl[2], mcode[2], nx[2], nd[2];

    logic [3:0] last_out0, last_out1, prev_out0;
    logic       last_done0, last_busy0, last_ready0, last_done1, last_ready1, last_busy1;
    int         run_len;
    int         strobe_q[$];
    int         width_q[$];

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        if (obs == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_dut(input int d, input logic [3:0] o, input logic dn,
                             input logic b, input logic rdy);
        int busy_e, rdy_e, done_e, out_e;
        busy_e = (hl[d] > 0 || gl[d] > 0) ? 1 : 0;
        rdy_e  = (busy_e == 0 && !abort) ? 1 : 0;
        done_e = (hl[d] == 1 && !abort) ? 1 : 0;
        out_e  = (hl[d] > 0) ? (1 << mcode[d]) : 0;
        check_val($sformatf("d%0d_out", d), int'(o), out_e);
        check_val($sformatf("d%0d_done", d), int'(dn), done_e);
        check_val($sformatf("d%0d_busy", d), int'(b), busy_e);
        check_val($sformatf("d%0d_ready", d), int'(rdy), rdy_e);
        check_val($sformatf("d%0d_onehot", d), ($countones(o) <= 1) ? 1 : 0, 1);
        if (dn) begin
            nd[d]++;
            check_val($sformatf("d%0d_done_src", d), (nd[d] <= nx[d]) ? 1 : 0, 1);
        end
    endtask

    task automatic model_step(input int d);
        if (rst) begin
            hl[d] = 0; gl[d] = 0; mcode[d] = 0;
            nd[d] = nx[d];
        end else if (abort && (hl[d] > 0 || gl[d] > 0)) begin
            hl[d] = 0; gl[d] = 0;
        end else if (hl[d] > 0) begin
            hl[d]--;
        end else if (gl[d] > 0) begin
            gl[d]--;
        end else if (in_valid && !abort) begin
            hl[d] = hc[d]; gl[d] = gc[d]; mcode[d] = int'(in_code);
            nx[d]++;
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic [1:0] c, input logic a);
        @(negedge clk);
        rst = r; in_valid = v; in_code = c; abort = a;
        #1;
        last_out0 = out0; last_done0 = done0; last_busy0 = busy0; last_ready0 = in_ready0;
        last_out1 = out1; last_done1 = done1; last_busy1 = busy1; last_ready1 = in_ready1;
        check_dut(0, out0, done0, busy0, in_ready0);
        check_dut(1, out1, done1, busy1, in_ready1);
        // log observed strobes of the 4/1 instance by value and width
        if (out0 != 4'b0000 && out0 != prev_out0) begin
            strobe_q.push_back(int'(out0));
            run_len = 1;
        end else if (out0 != 4'b0000) begin
            run_len++;
        end else if (prev_out0 != 4'b0000) begin
            width_q.push_back(run_len);
        end
        prev_out0 = out0;
        @(posedge clk);
        model_step(0);
        model_step(1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        int k, guard;
        logic r, v, a;
        logic [1:0] c;
        rst = 1'b1; in_valid = 1'b0; in_code = 2'd0; abort = 1'b0;
        prev_out0 = 4'b0000; run_len = 0;
        for (int d = 0; d < 2; d++) begin
            hl[d] = 0; gl[d] = 0; mcode[d] = 0; nx[d] = 0; nd[d] = 0;
        end
        repeat (2) @(posedge clk);

        // Reset state
        cycle(1'b0, 1'b0, 2'd0, 1'b0);
        check_val("rst_ready", int'(last_ready0), 1);
        check_val("rst_out", int'(last_out0), 0);

        // Single code 2: four cycles of 0100, done on the fourth, one gap cycle
        cycle(1'b0, 1'b1, 2'd2, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            idle(1);
            check_val("single_out", int'(last_out0), 4);
            check_val("single_done", int'(last_done0), (i == 4) ? 1 : 0);
        end
        idle(1);
        check_val("single_gap_out", int'(last_out0), 0);
        check_val("single_gap_busy", int'(last_busy0), 1);
        idle(1);
        check_val("single_ready", int'(last_ready0), 1);

        // Back-to-back sweep with in_valid held high
        strobe_q.delete(); width_q.delete();
        k = 0; guard = 0;
        while (k < 4 && guard < 200) begin
            cycle(1'b0, 1'b1, 2'(k), 1'b0);
            if (last_ready0) k++;
            guard++;
        end
        check_val("sweep_guard", (guard < 200) ? 1 : 0, 1);
        idle(8);
        check_val("sweep_count", strobe_q.size(), 4);
        check_val("sweep_widths", width_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < strobe_q.size()) check_val("sweep_code", strobe_q[i], 1 << i);
            if (i < width_q.size())  check_val("sweep_width", width_q[i], 4);
        end

        // Abort in the second hold cycle of code 3
        cycle(1'b0, 1'b1, 2'd3, 1'b0);
        idle(1);
        cycle(1'b0, 1'b0, 2'd0, 1'b1);
        check_val("abort_done", int'(last_done0), 0);
        idle(1);
        check_val("abort_out", int'(last_out0), 0);
        check_val("abort_busy", int'(last_busy0), 0);
        idle(3);

        // Abort in idle blocks a concurrently offered code
        cycle(1'b0, 1'b1, 2'd1, 1'b1);
        check_val("idle_abort_ready", int'(last_ready0), 0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check_val("idle_abort_out", int'(last_out0), 0);
        end

        // Reset during the gap cycle; 1/0 instance strobes a single cycle
        cycle(1'b0, 1'b1, 2'd2, 1'b0);
        idle(1);
        check_val("h1_out", int'(last_out1), 4);
        check_val("h1_done", int'(last_done1), 1);
        idle(1);
        check_val("h1_ready", int'(last_ready1), 1);
        check_val("h1_busy", int'(last_busy1), 0);
        idle(2);
        cycle(1'b1, 1'b0, 2'd0, 1'b0);
        check_val("gap_before_rst", int'(last_busy0), 1);
        idle(1);
        check_val("gap_rst_busy", int'(last_busy0), 0);
        check_val("gap_rst_out", int'(last_out0), 0);
        check_val("gap_rst_done", int'(last_done0), 0);
        check_val("gap_rst_ready", int'(last_ready0), 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 2) != 0);
            c = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 11) == 0);
            cycle(r, v, c, a);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
